iterative_alu: RTL and testbench

- Execute-stage ALU for the pipelined CPU; consumes the 3-bit ALU control code produced by the ALU control decoder, plus two 32-bit operands from the ID/EX register.
- Single-cycle ops return a registered result one cycle after start.
- MUL uses an iterative shift-add engine, one multiplier bit per cycle.
- busy_o drives the hazard unit to stall IF/ID/EX while a multiply is in flight.

---
 rtl/iterative_alu.sv | 185 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// ---------------------------------------------------------------------------
// iterative_alu
//
// Execute-stage ALU for the pipelined CPU.
// - Single-cycle operations produce a registered result one cycle after start.
// - MUL runs a shift-add engine that consumes one multiplier bit per cycle.
// - busy_o tells the hazard unit to stall IF/ID/EX while a multiply runs.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous reset, active low
//   start_i    operation request, only sampled while idle
//   ALUCtrl_i  000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL,
//              110 NoOp, 111 SRAI (any other value behaves as ADD)
//   data1_i    operand A (rs1)
//   data2_i    operand B (rs2 or immediate)
//   data_o     registered result, held between operations
//   zero_o     registered (data_o == 0)
//   done_o     one-cycle pulse marking a new valid data_o
//   busy_o     high while a multiply is in flight
//
// Build option:
//   ALU_MUL_EARLY_TERM_EN  stop the multiply as soon as the remaining
//                          multiplier bits are all zero. Results are the
//                          same in both builds; only the latency differs.
// ---------------------------------------------------------------------------
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL = 3'b101;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   step_q, step_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] alu_result;
  logic [SHW-1:0]   shamt;

  // Single-cycle datapath. MUL never uses this result; unknown codes fall
  // through to ADD.
  always_comb begin
    alu_result = data1_i + data2_i;
    shamt      = data2_i[SHW-1:0];
    case (ALUCtrl_i)
      3'b000:  alu_result = data1_i & data2_i;
      3'b001:  alu_result = data1_i ^ data2_i;
      3'b010:  alu_result = data1_i << shamt;
      3'b011:  alu_result = data1_i + data2_i;
      3'b100:  alu_result = data1_i - data2_i;
      3'b101:  alu_result = '0;
      3'b110:  alu_result = '0;
      3'b111:  alu_result = $signed(data1_i) >>> shamt;
      default: alu_result = data1_i + data2_i;
    endcase
  end

  // Control FSM and multiply engine next-state logic.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    step_d   = step_q;
    data_d   = data_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            step_d   = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
`ifdef ALU_MUL_EARLY_TERM_EN
            // Nothing to accumulate: skip straight to the result stage,
            // busy still shows for that single cycle.
            if (data2_i == '0) begin
              state_d = S_DONE;
            end
`endif
          end else begin
            data_d = alu_result;
            zero_d = (alu_result == '0);
            done_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + SHW'(1);
        // busy drops on the same edge that enters DONE so it is high for
        // exactly the cycles spent stepping.
        if (step_q == SHW'(WIDTH - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end
`ifdef ALU_MUL_EARLY_TERM_EN
        if ((mplier_q >> 1) == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end
`endif
      end

      S_DONE: begin
        data_d  = acc_q;
        zero_d  = (acc_q == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign data_o = data_q;
  assign zero_o = zero_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_iterative_alu.sv
// ---------------------------------------------------------------------------
// tb_iterative_alu
//
// Self-checking bench for iterative_alu (WIDTH = 32). Expected results come
// from a reference model built on plain arithmetic; expected latencies and
// busy durations come from the operand values. Define ALU_MUL_EARLY_TERM_EN
// for both bench and design to check the early-terminating multiply.
// ---------------------------------------------------------------------------
module tb_iterative_alu;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             done_o;
  logic             busy_o;

  int checks   = 0;
  int failures = 0;

  iterative_alu #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: what the ALU should compute for a code and operands.
  function automatic logic [31:0] refResult(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] prod;
    logic signed [31:0] sa;
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a << b[4:0];
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[31:0];
      end
      3'd6: return 32'd0;
      default: begin
        sa = $signed(a);
        return sa >>> b[4:0];
      end
    endcase
  endfunction

  // Number of significant bits in the multiplier (0 for zero).
  function automatic int sigBits(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] b);
    if (op != 3'd5) return 1;
`ifdef ALU_MUL_EARLY_TERM_EN
    if (b == 32'd0) return 2;
    return 2 + sigBits(b);
`else
    return WIDTH + 2;
`endif
  endfunction

  function automatic int expBusy(input logic [2:0] op, input logic [31:0] b);
    if (op != 3'd5) return 0;
`ifdef ALU_MUL_EARLY_TERM_EN
    if (b == 32'd0) return 1;
    return sigBits(b);
`else
    return WIDTH;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse, checking result,
  // zero flag, latency, busy duration and that done drops afterwards.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 0;
    logic [31:0] exp;
    exp = refResult(op, a, b);
    @(negedge clk_i);
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    start_i   = 1'b1;
    while (!got && lat < 100) begin
      @(negedge clk_i);
      start_i = 1'b0;
      lat++;
      if (busy_o) busy_cnt++;
      if (done_o) got = 1;
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
    checkOutput("data", data_o, exp);
    checkOutput("zero", {31'd0, zero_o}, {31'd0, (exp == 32'd0)});
    checkOutput("latency", lat, expLatency(op, b));
    checkOutput("busy_cycles", busy_cnt, expBusy(op, b));
    @(negedge clk_i);
    checkOutput("done_single", {31'd0, done_o}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t seq[5];

  initial begin
    int lat;
    int done_cnt;
    int done_at;
    logic [31:0] done_data;
    logic prev_done;
    logic [2:0] rop;

    rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = 3'd0;
    data1_i = '0; data2_i = '0;

    // Power-on reset, observed before any clock edge.
    #3 rst_i = 1'b0;
    #1;
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_zero", {31'd0, zero_o}, 32'd1);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed single-cycle operations issued back to back.
    seq[0] = '{3'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F};
    seq[1] = '{3'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F};
    seq[2] = '{3'd4, 32'd5, 32'd5};
    seq[3] = '{3'd2, 32'd1, 32'd31};
    seq[4] = '{3'd7, 32'h8000_0000, 32'd4};
    @(negedge clk_i);
    ALUCtrl_i = seq[0].op; data1_i = seq[0].a; data2_i = seq[0].b;
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("b2b_done", {31'd0, done_o}, 32'd1);
      checkOutput("b2b_data", data_o, refResult(seq[i].op, seq[i].a, seq[i].b));
      checkOutput("b2b_zero", {31'd0, zero_o},
                  {31'd0, (refResult(seq[i].op, seq[i].a, seq[i].b) == 32'd0)});
      if (i < 4) begin
        ALUCtrl_i = seq[i+1].op; data1_i = seq[i+1].a; data2_i = seq[i+1].b;
      end else begin
        start_i = 1'b0;
      end
    end
    @(negedge clk_i);
    checkOutput("b2b_idle_done", {31'd0, done_o}, 32'd0);
    checkOutput("hold_data", data_o, 32'hF800_0000);

    // Asynchronous reset between clock edges with a nonzero result held.
    #2 rst_i = 1'b0;
    #1;
    checkOutput("arst_data", data_o, 32'd0);
    checkOutput("arst_zero", {31'd0, zero_o}, 32'd1);
    checkOutput("arst_done", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed operations.
    applyStimulus(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(3'd5, 32'd7, 32'd6);
    applyStimulus(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(3'd5, 32'd3, 32'd5);
    applyStimulus(3'd5, 32'd9, 32'd0);

    // Starts during busy and during the result stage must be ignored.
    lat = expLatency(3'd5, 32'd6);
    done_cnt = 0; done_at = 0; done_data = '0; prev_done = 1'b0;
    @(negedge clk_i);
    ALUCtrl_i = 3'd5; data1_i = 32'd7; data2_i = 32'd6; start_i = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        done_cnt++;
        done_at = c;
        done_data = data_o;
        if (prev_done) checkOutput("ign_double_done", 32'd1, 32'd0);
      end
      prev_done = done_o;
      if (c == 2 || c == lat - 1) begin
        ALUCtrl_i = 3'd3; data1_i = 32'd1; data2_i = 32'd1; start_i = 1'b1;
      end
    end
    checkOutput("ign_done_count", done_cnt, 32'd1);
    checkOutput("ign_done_at", done_at, lat);
    checkOutput("ign_data", done_data, 32'd42);

    // Reset in the middle of a multiply aborts it without a done pulse.
    @(negedge clk_i);
    ALUCtrl_i = 3'd5; data1_i = 32'd7; data2_i = 32'hFFFF_FFFF; start_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #2 rst_i = 1'b0;
    #1;
    checkOutput("mrst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("mrst_done", {31'd0, done_o}, 32'd0);
    checkOutput("mrst_data", data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
    checkOutput("mrst_no_done", done_cnt, 32'd0);
    applyStimulus(3'd3, 32'd2, 32'd3);

    // Randomised operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (i % 4 == 3) rop = 3'd5;
      applyStimulus(rop, $urandom, (i % 8 == 7) ? ($urandom & 32'h0000_00FF) : $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
